// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder: one full-adder cell, registered carry, LSB first
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds the sub port for a-b)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sr_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, cout_q, ovf_q;

  logic             load, last, sub_eff, c_init;
  logic             b_bit, s_bit, c_nx;
  logic [WIDTH-1:0] sr_shift;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q;

  // Subtract select is latched with the operands so it cannot change mid-operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else if (load) begin
      sub_q <= sub;
    end
  end

  // Subtraction is a + ~b + 1, so the carry seeds to 1 and cin is ignored
  always_comb begin
    sub_eff = sub_q;
    c_init  = sub ? 1'b1 : cin;
  end
`else
  // Pure addition: no inversion, carry seeds from cin
  always_comb begin
    sub_eff = 1'b0;
    c_init  = cin;
  end
`endif

  // Full-adder cell and the LSB-first shift of its sum bit into the MSB
  always_comb begin
    load     = start && ((state_q == IDLE) || (state_q == DONE));
    last     = (state_q == RUN) && (cnt_q == LAST);
    b_bit    = b_q[0] ^ sub_eff;
    s_bit    = a_q[0] ^ b_bit ^ c_q;
    c_nx     = (a_q[0] & b_bit) | (b_bit & c_q) | (c_q & a_q[0]);
    sr_shift = (sr_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only looked at in IDLE and DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs plus the result registers, which only move on entry to DONE
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    sum  = sum_q;
    cout = cout_q;
    ovf  = ovf_q;
  end

  // Operand shifters, carry, bit counter and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sr_q   <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (load) begin
      a_q   <= a;
      b_q   <= b;
      c_q   <= c_init;
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (state_q == RUN) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      c_q   <= c_nx;
      sr_q  <= sr_shift;
      cnt_q <= cnt_q + CW'(1);
      if (last) begin
        // c_q here is the carry into the MSB, c_nx the carry out of it
        sum_q  <= sr_shift;
        cout_q <= c_nx;
        ovf_q  <= c_q ^ c_nx;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH=8 and WIDTH=1)
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, cin, sub;
  logic [7:0] a, b;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;

  logic       start1, cin1, sub1;
  logic [0:0] a1, b1;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] sum1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub1),
`endif
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1),
    .ovf   (ovf1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present operands with start for one accepted edge; returns 1ns after that edge
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic cv, input logic sv);
    start = 1'b1;
    a     = av;
    b     = bv;
    cin   = cv;
    sub   = sv;
    @(posedge clk); #1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    cin   = 1'b0;
    sub   = 1'b0;
  endtask

  // Count clocks until done (bounded) and how many of them had busy high
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat, bcnt;
    bit seen;
    rst_n = 1'b0;
    start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; sub1 = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum",  sum,  8'h00);
    check("rst_cout", cout, 0);
    check("rst_ovf",  ovf,  0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FF + 01: full carry ripple, carry into MSB equals carry out
    start_op(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done(lat, bcnt);
    check("t1_lat",  lat,  8);
    check("t1_busy_cycles", bcnt, 8);
    check("t1_busy_at_done", busy, 0);
    check("t1_sum",  sum,  8'h00);
    check("t1_cout", cout, 1);
    check("t1_ovf",  ovf,  0);
    @(posedge clk); #1;
    check("t1_done_pulse", done, 0);
    check("t1_idle_busy",  busy, 0);

    // 7F + 01: signed overflow, then back-to-back with start held in DONE
    start_op(8'h7F, 8'h01, 1'b0, 1'b0);
    wait_done(lat, bcnt);
    check("t2_lat",  lat,  8);
    check("t2_sum",  sum,  8'h80);
    check("t2_cout", cout, 0);
    check("t2_ovf",  ovf,  1);
    start_op(8'h10, 8'h20, 1'b1, 1'b0);
    check("t2_b2b_busy", busy, 1);
    wait_done(lat, bcnt);
    check("t2_b2b_period", lat + 1, 9);
    check("t2_b2b_sum",  sum,  8'h31);
    check("t2_b2b_cout", cout, 0);
    check("t2_b2b_ovf",  ovf,  0);
    @(posedge clk); #1;

    // Second start during RUN must be ignored; old sum held until done
    start_op(8'h03, 8'h04, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; a = 8'hAA; b = 8'h04;
    @(posedge clk); #1;
    start = 1'b0; a = 8'h00; b = 8'h00;
    check("t3_held_sum", sum, 8'h31);
    check("t3_busy_mid", busy, 1);
    wait_done(lat, bcnt);
    check("t3_lat_rest", lat, 4);
    check("t3_sum", sum, 8'h07);
    @(posedge clk); #1;
    check("t3_no_retrigger", busy, 0);

    // Asynchronous reset mid-RUN: outputs clear at once, no done follows
    start_op(8'h55, 8'h0F, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_rst_busy", busy, 0);
    check("t4_rst_done", done, 0);
    check("t4_rst_sum",  sum,  8'h00);
    check("t4_rst_cout", cout, 0);
    check("t4_rst_ovf",  ovf,  0);
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
    check("t4_no_done_after_rst", seen, 0);
    start_op(8'h01, 8'h01, 1'b0, 1'b0);
    wait_done(lat, bcnt);
    check("t4_lat", lat, 8);
    check("t4_sum", sum, 8'h02);
    @(posedge clk); #1;

    // WIDTH=1: every {a,b,cin}, latency of one clock
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic       es, ec;
      v  = i[2:0];
      es = v[2] ^ v[1] ^ v[0];
      ec = (v[2] & v[1]) | (v[1] & v[0]) | (v[0] & v[2]);
      start1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0];
      @(posedge clk); #1;
      start1 = 1'b0;
      check($sformatf("w1_busy_%0d", i), busy1, 1);
      @(posedge clk); #1;
      check($sformatf("w1_done_%0d", i), done1, 1);
      check($sformatf("w1_sum_%0d", i),  sum1,  es);
      check($sformatf("w1_cout_%0d", i), cout1, ec);
      check($sformatf("w1_ovf_%0d", i),  ovf1,  v[0] ^ ec);
      @(posedge clk); #1;
    end

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction: cin ignored, cout=1 means no borrow
    start_op(8'h05, 8'h07, 1'b1, 1'b1);
    wait_done(lat, bcnt);
    check("sub1_lat",  lat,  8);
    check("sub1_sum",  sum,  8'hFE);
    check("sub1_cout", cout, 0);
    check("sub1_ovf",  ovf,  0);
    @(posedge clk); #1;
    start_op(8'h80, 8'h01, 1'b0, 1'b1);
    wait_done(lat, bcnt);
    check("sub2_sum",  sum,  8'h7F);
    check("sub2_cout", cout, 1);
    check("sub2_ovf",  ovf,  1);
    @(posedge clk); #1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
